alu_issue_ctrl: RTL and testbench

//  Multi-cycle initiator for the 32-bit ALU: accepts MIPS instruction words, decodes them into the ALU's 3-bit op, and fetches operands from the register file.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_issue_ctrl_if.sv | 38 +++
 rtl/alu_decode.sv | 66 ++++++
 rtl/alu_issue_ctrl.sv | 121 ++++++++++++
 tb/tb_alu_issue_ctrl.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: ALU op codes, MIPS opcode/funct values,
// FSM state encoding and the decoded-instruction record.
package alu_pkg;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_RESP
    } state_t;

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [2:0] op;
        logic       use_imm;
        logic [4:0] dest;
        logic       wr_en;
        logic       is_beq;
        logic       illegal;
    } decode_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Bundle of the fetch, register-file, ALU and write-back signals around the issue controller.
interface alu_issue_ctrl_if #(
    parameter int W    = 32,
    parameter int RA_W = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [RA_W-1:0] rf_rs_addr;
    logic [RA_W-1:0] rf_rt_addr;
    logic [W-1:0]    rf_rs_data;
    logic [W-1:0]    rf_rt_data;
    logic [W-1:0]    alu_a;
    logic [W-1:0]    alu_b;
    logic [2:0]      alu_op;
    logic [W-1:0]    alu_z;
    logic            alu_zero;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_result;
    logic [RA_W-1:0] out_dest;
    logic            out_wr_en;
    logic            out_taken;
    logic            out_illegal;

    modport master (
        input  in_valid, in_instr, rf_rs_data, rf_rt_data, alu_z, alu_zero, out_ready,
        output in_ready, rf_rs_addr, rf_rt_addr, alu_a, alu_b, alu_op,
               out_valid, out_result, out_dest, out_wr_en, out_taken, out_illegal
    );

    modport slave (
        output in_valid, in_instr, rf_rs_data, rf_rt_data, alu_z, alu_zero, out_ready,
        input  in_ready, rf_rs_addr, rf_rt_addr, alu_a, alu_b, alu_op,
               out_valid, out_result, out_dest, out_wr_en, out_taken, out_illegal
    );

endinterface

// File: rtl/alu_decode.sv
// Combinational MIPS decoder: instruction word -> ALU op, operand source, destination and flags.
module alu_decode
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [31:0]  instr,
    output decode_t      dec,
    output logic [W-1:0] imm_ext
);

    logic [5:0] opc;
    logic [5:0] funct;

    assign opc     = instr[31:26];
    assign funct   = instr[5:0];
    assign imm_ext = {{(W-16){instr[15]}}, instr[15:0]};

    always_comb begin
        dec         = '0;
        dec.rs      = instr[25:21];
        dec.rt      = instr[20:16];
        case (opc)
            OPC_RTYPE: begin
                dec.dest  = instr[15:11];
                dec.wr_en = 1'b1;
                case (funct)
                    FN_ADD:  dec.op = ALU_ADD;
                    FN_SUB:  dec.op = ALU_SUB;
                    FN_AND:  dec.op = ALU_AND;
                    FN_OR:   dec.op = ALU_OR;
                    FN_SLT:  dec.op = ALU_SLT;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OPC_ADDI, OPC_LW: begin
                dec.op      = ALU_ADD;
                dec.use_imm = 1'b1;
                dec.dest    = instr[20:16];
                dec.wr_en   = 1'b1;
            end
            OPC_SW: begin
                dec.op      = ALU_ADD;
                dec.use_imm = 1'b1;
                dec.dest    = instr[20:16];
            end
            OPC_BEQ: begin
                dec.op     = ALU_SUB;
                dec.dest   = instr[20:16];
                dec.is_beq = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase

        // r0 is hardwired to zero, so a write to it is dropped while the result is still reported
        if (dec.illegal) begin
            dec.op    = ALU_AND;
            dec.dest  = '0;
            dec.wr_en = 1'b0;
        end
        if (dec.dest == 5'd0) begin
            dec.wr_en = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue controller: decodes an instruction, reads the register file, runs it through
// the external ALU and returns a write-back/branch record. One instruction in flight at a time.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int W    = 32,
    parameter int RA_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_ctrl_if.master bus
);

    state_t       state;
    state_t       next_state;
    decode_t      dec;
    decode_t      dec_q;
    logic [W-1:0] imm_ext;
    logic [W-1:0] imm_q;
    logic [W-1:0] alu_a_q;
    logic [W-1:0] alu_b_q;
    logic [2:0]   alu_op_q;
    logic [W-1:0] result_q;
    logic         taken_q;
    logic         accept;
    logic         load_ops;
    logic         capture;
    logic         in_ready;
    logic         out_valid;

    alu_decode #(.W(W)) u_decode (
        .instr   (bus.in_instr),
        .dec     (dec),
        .imm_ext (imm_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        load_ops   = 1'b0;
        capture    = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    next_state = dec.illegal ? ST_RESP : ST_READ;
                end
            end
            ST_READ: begin
                load_ops   = 1'b1;
                next_state = ST_EXEC;
            end
            ST_EXEC: begin
                capture    = 1'b1;
                next_state = ST_RESP;
            end
            ST_RESP: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Operands are registered so the ALU inputs stay put outside EXEC and the record stays stable in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_q    <= '0;
            imm_q    <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
            result_q <= '0;
            taken_q  <= 1'b0;
        end else begin
            if (accept) begin
                dec_q    <= dec;
                imm_q    <= imm_ext;
                result_q <= '0;
                taken_q  <= 1'b0;
            end
            if (load_ops) begin
                alu_a_q  <= bus.rf_rs_data;
                alu_b_q  <= dec_q.use_imm ? imm_q : bus.rf_rt_data;
                alu_op_q <= dec_q.op;
            end
            if (capture) begin
                result_q <= bus.alu_z;
                taken_q  <= dec_q.is_beq & bus.alu_zero;
            end
        end
    end

    // Addresses go out in the accept cycle so the synchronous read data lands during READ
    assign bus.rf_rs_addr  = accept ? dec.rs : dec_q.rs;
    assign bus.rf_rt_addr  = accept ? dec.rt : dec_q.rt;
    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_op      = alu_op_q;
    assign bus.out_result  = result_q;
    assign bus.out_dest    = dec_q.dest;
    assign bus.out_wr_en   = dec_q.wr_en;
    assign bus.out_taken   = taken_q;
    assign bus.out_illegal = dec_q.illegal;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU, a sync-read register file
// and an instruction-level reference model.
module tb_alu_issue_ctrl;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  dest;
        logic        wr_en;
        logic        taken;
        logic        illegal;
        logic [2:0]  op;
    } rec_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] rf [32];
    int          errors;
    int          checks;

    alu_issue_ctrl_if #(.W(32), .RA_W(5)) bus ();

    alu_issue_ctrl #(.W(32), .RA_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sync-read register file: data follows the address by one clock
    always @(posedge clk) begin
        bus.rf_rs_data <= rf[bus.rf_rs_addr];
        bus.rf_rt_data <= rf[bus.rf_rt_addr];
    end

    // The ALU the controller drives
    always_comb begin
        bus.alu_z = 32'h0;
        case (bus.alu_op)
            3'b000: bus.alu_z = bus.alu_a & bus.alu_b;
            3'b001: bus.alu_z = bus.alu_a | bus.alu_b;
            3'b010: bus.alu_z = bus.alu_a + bus.alu_b;
            3'b110: bus.alu_z = bus.alu_a - bus.alu_b;
            3'b111: bus.alu_z = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
            default: bus.alu_z = 32'h0;
        endcase
        bus.alu_zero = (bus.alu_z == 32'h0);
    end

    function automatic logic [31:0] rtype(input logic [5:0] fn, input int rs, input int rt, input int rd);
        logic [4:0] s, t, d;
        s = rs[4:0];
        t = rt[4:0];
        d = rd[4:0];
        return {6'h00, s, t, d, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] opc, input int rs, input int rt, input logic [15:0] imm);
        logic [4:0] s, t;
        s = rs[4:0];
        t = rt[4:0];
        return {opc, s, t, imm};
    endfunction

    // Instruction-level expectation from the register file contents
    function automatic rec_t model(input logic [31:0] instr);
        rec_t        r;
        logic [31:0] a, b, imm;
        r   = '0;
        a   = rf[instr[25:21]];
        b   = rf[instr[20:16]];
        imm = 32'($signed(instr[15:0]));
        if (instr[31:26] == 6'h00) begin
            r.dest  = instr[15:11];
            r.wr_en = 1'b1;
            case (instr[5:0])
                6'h20: begin r.result = a + b; r.op = 3'b010; end
                6'h22: begin r.result = a - b; r.op = 3'b110; end
                6'h24: begin r.result = a & b; r.op = 3'b000; end
                6'h25: begin r.result = a | b; r.op = 3'b001; end
                6'h2A: begin r.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; r.op = 3'b111; end
                default: r.illegal = 1'b1;
            endcase
        end else begin
            r.dest = instr[20:16];
            case (instr[31:26])
                6'h08, 6'h23: begin r.result = a + imm; r.op = 3'b010; r.wr_en = 1'b1; end
                6'h2B:        begin r.result = a + imm; r.op = 3'b010; end
                6'h04:        begin r.result = a - b; r.op = 3'b110; r.taken = (a == b); end
                default:      r.illegal = 1'b1;
            endcase
        end
        if (r.illegal) begin
            r.result = 32'h0;
            r.wr_en  = 1'b0;
        end
        if (r.dest == 5'd0) r.wr_en = 1'b0;
        return r;
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input rec_t exp);
        checkValue({tag, ".valid"},   32'(bus.out_valid), 32'd1);
        checkValue({tag, ".result"},  bus.out_result, exp.result);
        checkValue({tag, ".wr_en"},   32'(bus.out_wr_en), 32'(exp.wr_en));
        checkValue({tag, ".taken"},   32'(bus.out_taken), 32'(exp.taken));
        checkValue({tag, ".illegal"}, 32'(bus.out_illegal), 32'(exp.illegal));
        if (!exp.illegal) begin
            checkValue({tag, ".dest"},   32'(bus.out_dest), 32'(exp.dest));
            checkValue({tag, ".alu_op"}, 32'(bus.alu_op), 32'(exp.op));
        end
    endtask

    // One full transaction: accept, latency, optional backpressure, handshake, return to idle
    task automatic applyStimulus(input string tag, input logic [31:0] instr, input int holdCycles);
        rec_t exp;
        int   lat;
        exp = model(instr);
        @(negedge clk);
        checkValue({tag, ".in_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        checkValue({tag, ".latency"}, 32'(lat), exp.illegal ? 32'd1 : 32'd3);
        for (int i = 0; i < holdCycles; i++) begin
            checkOutput({tag, ".hold"}, exp);
            checkValue({tag, ".hold.in_ready"}, 32'(bus.in_ready), 32'd0);
            @(negedge clk);
        end
        checkOutput(tag, exp);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        checkValue({tag, ".post.valid"}, 32'(bus.out_valid), 32'd0);
        checkValue({tag, ".post.in_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        logic [5:0]  fnList [5];
        logic [5:0]  opList [4];
        logic [31:0] instr;
        int          k, rs, rt, rd;

        fnList = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        opList = '{6'h08, 6'h23, 6'h2B, 6'h04};
        errors = 0;
        checks = 0;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'h0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkValue("reset.in_ready", 32'(bus.in_ready), 32'd1);
        checkValue("reset.out_valid", 32'(bus.out_valid), 32'd0);
        checkValue("reset.out_result", bus.out_result, 32'd0);
        checkValue("reset.alu_a", bus.alu_a, 32'd0);
        checkValue("reset.alu_op", 32'(bus.alu_op), 32'd0);

        $display("[TB] directed: add");
        rf[1] = 32'd5;
        rf[2] = 32'd7;
        applyStimulus("add", rtype(6'h20, 1, 2, 3), 0);

        $display("[TB] directed: slt signed");
        rf[1] = 32'hFFFF_FFFF;
        rf[2] = 32'd1;
        applyStimulus("slt", rtype(6'h2A, 1, 2, 4), 0);
        applyStimulus("slt.swap", rtype(6'h2A, 2, 1, 4), 0);

        $display("[TB] directed: beq");
        rf[1] = 32'h1234;
        rf[2] = 32'h1234;
        applyStimulus("beq.taken", itype(6'h04, 1, 2, 16'h0010), 0);
        rf[2] = 32'h1235;
        applyStimulus("beq.not", itype(6'h04, 1, 2, 16'h0010), 0);

        $display("[TB] directed: addi sign extension and r0 destination");
        rf[1] = 32'h0;
        applyStimulus("addi", itype(6'h08, 1, 5, 16'hFFFF), 0);
        applyStimulus("addi.r0", itype(6'h08, 1, 0, 16'hFFFF), 0);

        $display("[TB] directed: illegal opcode");
        applyStimulus("illegal", itype(6'h3F, 1, 2, 16'h1234), 0);

        $display("[TB] directed: backpressure");
        rf[6] = 32'hF0F0_0000;
        rf[7] = 32'h0000_0F0F;
        applyStimulus("bp.or", rtype(6'h25, 6, 7, 8), 5);

        $display("[TB] directed: reset during EXEC");
        bus.in_valid = 1'b1;
        bus.in_instr = rtype(6'h20, 6, 7, 9);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkValue("rst.out_valid", 32'(bus.out_valid), 32'd0);
        checkValue("rst.in_ready", 32'(bus.in_ready), 32'd1);
        checkValue("rst.alu_a", bus.alu_a, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkValue("rst.no_record", 32'(bus.out_valid), 32'd0);
        end
        checkValue("rst.out_result", bus.out_result, 32'd0);

        $display("[TB] random instructions");
        for (int i = 1; i < 32; i++) rf[i] = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        for (int n = 0; n < 40; n++) begin
            k  = $urandom_range(0, 10);
            rs = $urandom_range(0, 31);
            rt = ($urandom_range(0, 3) == 0) ? rs : $urandom_range(0, 31);
            rd = $urandom_range(0, 31);
            if (k < 5) begin
                instr = rtype(fnList[k], rs, rt, rd);
                instr[10:6] = 5'($urandom_range(0, 31));
            end else if (k < 9) begin
                instr = itype(opList[k-5], rs, rt, 16'($urandom));
            end else if (k == 9) begin
                instr = rtype(6'h21, rs, rt, rd);
            end else begin
                instr = itype(6'h02, rs, rt, 16'($urandom));
            end
            applyStimulus("rand", instr, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
